// File: rtl/corescore_pll_reset_ctrl.sv
// rtl/corescore_pll_reset_ctrl.sv - PLL reset sequencer with lock qualification and relock counter
//
// Purpose:
//   Drives the PLL reset pin from the free-running board clock. It watches the
//   PLL lock indicator and re-arms the PLL when lock never arrives or is lost.
//   The system reset is released only after lock has held for STABLE_CYCLES.
//
// Ports:
//   i_clk          - free-running input clock, all logic on the rising edge
//   i_rst          - synchronous active-high reset
//   i_locked       - PLL LOCKED, asynchronous to i_clk
//   o_pll_rst      - PLL RST, active high, registered
//   o_rst          - qualified system reset, active high, registered
//   o_relock_count - saturating count of relock events

module corescore_pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  output logic       o_pll_rst,
  output logic       o_rst,
  output logic [7:0] o_relock_count
);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Terminal counts are the last cycle spent in a state, hence the -1.
  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  relock_q, relock_d;
  logic        pll_rst_q, pll_rst_d;
  logic        rst_q, rst_d;
  logic        sync1_q, sync1_d;
  logic        lock_s_q, lock_s_d;
  logic        relock_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= 1'b1;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      sync1_q   <= sync1_d;
      lock_s_q  <= lock_s_d;
    end
  end

  // Two-flop synchronizer; only lock_s_q is used by the state machine.
  always_comb begin
    sync1_d  = i_locked;
    lock_s_d = sync1_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    relock_inc = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STABLE: begin
        // Lock is checked ahead of the terminal count so a drop on the last
        // qualification cycle still falls back to WAIT_LOCK.
        if (!lock_s_q)                   state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)   state_d = S_RUN;
        else                             cnt_d   = cnt_q + 16'd1;
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d    = S_PLL_RST;
          relock_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    // A single shared counter: every state starts counting from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // Saturating relock counter; wrapping would hide a persistently bad PLL.
  always_comb begin
    relock_d = relock_q;
    if (relock_inc && (relock_q != 8'hFF)) relock_d = relock_q + 8'd1;
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == S_PLL_RST);
    rst_d     = (state_d != S_RUN);
  end

  assign o_pll_rst      = pll_rst_q;
  assign o_rst          = rst_q;
  assign o_relock_count = relock_q;

endmodule

// File: tb/tb_corescore_pll_reset_ctrl.sv
// tb/tb_corescore_pll_reset_ctrl.sv - scoreboard bench for corescore_pll_reset_ctrl

module tb_corescore_pll_reset_ctrl;

  logic       clk;
  logic       i_rst;
  logic       i_locked;
  logic       o_pll_rst;
  logic       o_rst;
  logic [7:0] o_relock_count;

  int total = 0;
  int bad   = 0;

  // One entry per clock edge: stimulus applied before the edge and the
  // outputs required just after it. Edge 0 of every scenario is the reset edge.
  typedef struct packed {
    logic       rs;
    logic       lk;
    logic       pll;
    logic       rst;
    logic [7:0] cnt;
  } sb_t;

  sb_t sb_q[$];

  corescore_pll_reset_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_locked       (i_locked),
    .o_pll_rst      (o_pll_rst),
    .o_rst          (o_rst),
    .o_relock_count (o_relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic rs, input logic lk, input logic pll,
                      input logic rst, input int cnt);
    sb_t e;
    e.rs  = rs;
    e.lk  = lk;
    e.pll = pll;
    e.rst = rst;
    e.cnt = 8'(cnt);
    sb_q.push_back(e);
  endtask

  // Lock held low: PLL_RST for 4 edges then WAIT_LOCK for 32, a 36-edge period.
  task automatic test_reset_timeout();
    int k;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 76; n++) push(1'b0, 1'b0, (n % 36) < 4, 1'b1, n / 36);
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL reset_timeout edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  // WAIT_LOCK entered at edge 4; lock first sampled at 9, STABLE at 11, RUN at 19.
  task automatic test_lock_acquire();
    int k;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 24; n++) push(1'b0, n >= 9, n < 4, n < 19, 0);
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL lock_acquire edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  // Lock low at edges 17..19. lock_s drops exactly on the last STABLE cycle
  // (edge 19), so RUN must not be entered; relock qualifies again at 22 -> RUN at 30.
  task automatic test_stable_drop();
    int k;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 34; n++)
      push(1'b0, (n >= 9) && !((n >= 17) && (n <= 19)), n < 4, n < 30, 0);
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL stable_drop edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  // RUN from 19; one-cycle drop sampled at 25 -> PLL_RST at 27 (4 edges),
  // WAIT_LOCK at 31 with lock already present -> STABLE at 32 -> RUN at 40.
  task automatic test_run_glitch();
    int k;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 44; n++)
      push(1'b0, (n >= 9) && (n != 25), (n < 4) || ((n >= 27) && (n <= 30)),
           (n < 19) || ((n >= 27) && (n < 40)), (n >= 27) ? 1 : 0);
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL run_glitch edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  // 300 timeouts; the count must stop at 255.
  task automatic test_saturate();
    int k;
    int c;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 300 * 36 + 2; n++) begin
      c = n / 36;
      if (c > 255) c = 255;
      push(1'b0, 1'b0, (n % 36) < 4, 1'b1, c);
    end
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL saturate edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  // Three timeouts give count=3, then lock from 113 -> RUN at 123. A one-edge
  // reset at 126 clears everything; restart with lock present -> RUN at 139.
  task automatic test_reset_in_run();
    int k;
    sb_t e;
    push(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 1; n <= 143; n++) begin
      if (n < 113)       push(1'b0, 1'b0, (n % 36) < 4, 1'b1, n / 36);
      else if (n < 126)  push(1'b0, 1'b1, 1'b0, n < 123, 3);
      else if (n == 126) push(1'b1, 1'b1, 1'b1, 1'b1, 0);
      else               push(1'b0, 1'b1, n < 130, n < 139, 0);
    end
    k = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      i_rst = e.rs;
      i_locked = e.lk;
      @(posedge clk); #1;
      total++;
      if ({o_pll_rst, o_rst, o_relock_count} !== {e.pll, e.rst, e.cnt}) begin
        bad++;
        $display("FAIL reset_in_run edge=%0d got pll=%b rst=%b cnt=%0d want pll=%b rst=%b cnt=%0d",
                 k, o_pll_rst, o_rst, o_relock_count, e.pll, e.rst, e.cnt);
      end
      k++;
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_locked = 1'b0;
    test_reset_timeout();
    test_lock_acquire();
    test_stable_drop();
    test_run_glitch();
    test_saturate();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
